// File: rtl/acl_poll_pkg.sv
// Shared constants and state types for the ADXL362 poller.
package acl_poll_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FRAME_W  = 40;
  localparam int unsigned INIT_W   = 24;
  localparam int unsigned BITCNT_W = $clog2(FRAME_W + 1);

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_X      = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_Y      = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_Z      = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_CNT    = 5'd4;

  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] REG_XDATA     = 8'h08;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  // Frames are MSB-aligned; the shifter sends from bit FRAME_W-1 down.
  localparam logic [FRAME_W-1:0] READ_FRAME = {CMD_READ, REG_XDATA, 24'h000000};
  localparam logic [FRAME_W-1:0] INIT_FRAME = {CMD_WRITE, REG_POWER_CTL, PWR_MEASURE, 16'h0000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ASSERT,
    ST_SHIFT,
    ST_DEASSERT,
    ST_UPDATE
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ASSERT,
    PH_LOW,
    PH_HIGH,
    PH_DEASSERT
  } phase_t;

endpackage

// File: rtl/acl_spi_shifter.sv
// Generic N-bit SPI mode-0 shift engine; owns ss_n/sclk/mosi phase timing.
module acl_spi_shifter
  import acl_poll_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 50,
  parameter int unsigned N        = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [$clog2(N+1)-1:0] nbits,
  input  logic [N-1:0]           tx,
  input  logic                   miso,
  output logic                   assert_end_c,
  output logic                   shift_end_c,
  output logic                   done_c,
  output logic [N-1:0]           rx,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   ss_n
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W = $clog2(N + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);

  phase_t           phase;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bits_left;
  logic [N-1:0]     tx_sr;
  logic             div_end;

  assign div_end      = (div_cnt == '0);
  assign assert_end_c = (phase == PH_ASSERT) && div_end;
  assign shift_end_c  = (phase == PH_HIGH) && div_end && (bits_left == '0);
  assign done_c       = (phase == PH_DEASSERT) && div_end;

  // Each phase lasts SCLK_DIV cycles; MISO is taken on the sclk-rise edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= PH_IDLE;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sr     <= '0;
      rx        <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= 1'b1;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start) begin
            phase     <= PH_ASSERT;
            div_cnt   <= DIV_LOAD;
            bits_left <= nbits - BIT_W'(1);
            tx_sr     <= tx;
            rx        <= '0;
            mosi      <= tx[N-1];
            sclk      <= 1'b0;
            ss_n      <= 1'b0;
          end
        end
        PH_ASSERT: begin
          if (div_end) begin
            phase   <= PH_LOW;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        PH_LOW: begin
          if (div_end) begin
            phase   <= PH_HIGH;
            div_cnt <= DIV_LOAD;
            sclk    <= 1'b1;
            rx      <= {rx[N-2:0], miso};
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        PH_HIGH: begin
          if (div_end) begin
            sclk    <= 1'b0;
            div_cnt <= DIV_LOAD;
            if (bits_left == '0) begin
              phase <= PH_DEASSERT;
              mosi  <= 1'b0;
            end else begin
              phase     <= PH_LOW;
              bits_left <= bits_left - BIT_W'(1);
              tx_sr     <= {tx_sr[N-2:0], 1'b0};
              mosi      <= tx_sr[N-2];
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        PH_DEASSERT: begin
          if (div_end) begin
            phase <= PH_IDLE;
            ss_n  <= 1'b1;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acl_poll_ctrl.sv
// Autonomous ADXL362 X/Y/Z poller behind one MMIO slot.
// Define ACL_POLL_INIT_EN to send a POWER_CTL measurement-mode write before the first poll.
module acl_poll_ctrl
  import acl_poll_pkg::*;
#(
  parameter int unsigned SCLK_DIV    = 50,
  parameter int unsigned POLL_PERIOD = 100_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              acl_sclk,
  output logic              acl_mosi,
  input  logic              acl_miso,
  output logic              acl_ss_n
);

  localparam int unsigned TMR_W = $clog2(POLL_PERIOD + 1);

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic                 enable;
  logic                 new_flag;
  logic                 frame_init;
  logic [7:0]           x_q;
  logic [7:0]           y_q;
  logic [7:0]           z_q;
  logic [15:0]          sample_cnt;

  logic                 reg_wr_c;
  logic                 timer_done_c;
  logic                 start_c;
  logic                 init_pending_c;
  logic                 busy_c;
  logic                 assert_end_c;
  logic                 shift_end_c;
  logic                 done_c;
  logic [BITCNT_W-1:0]  nbits_c;
  logic [FRAME_W-1:0]   tx_word_c;
  logic [FRAME_W-1:0]   rx_word;
  logic                 unused_c;

  assign reg_wr_c     = cs && write;
  assign timer_done_c = (timer == '0);
  // UPDATE may launch the next frame directly when the period is shorter than a frame.
  assign start_c      = enable && timer_done_c && ((state == ST_WAIT) || (state == ST_UPDATE));
  assign busy_c       = (state != ST_IDLE) && (state != ST_WAIT);
  assign nbits_c      = init_pending_c ? BITCNT_W'(INIT_W) : BITCNT_W'(FRAME_W);
  assign tx_word_c    = init_pending_c ? INIT_FRAME : READ_FRAME;
  assign unused_c     = ^{read, wr_data[DATA_W-1:1], rx_word[FRAME_W-1:24]};

`ifdef ACL_POLL_INIT_EN
  logic init_done;

  // Only the very first frame after reset is the configuration write.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done <= 1'b0;
    end else if (start_c) begin
      init_done <= 1'b1;
    end
  end

  assign init_pending_c = !init_done;
`else
  assign init_pending_c = 1'b0;
`endif

  acl_spi_shifter #(
    .SCLK_DIV (SCLK_DIV),
    .N        (FRAME_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .start        (start_c),
    .nbits        (nbits_c),
    .tx           (tx_word_c),
    .miso         (acl_miso),
    .assert_end_c (assert_end_c),
    .shift_end_c  (shift_end_c),
    .done_c       (done_c),
    .rx           (rx_word),
    .sclk         (acl_sclk),
    .mosi         (acl_mosi),
    .ss_n         (acl_ss_n)
  );

  // Poll FSM, period timer and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      enable     <= 1'b0;
      new_flag   <= 1'b0;
      frame_init <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      sample_cnt <= '0;
    end else begin
      if (reg_wr_c && (addr == ADDR_STATUS)) enable <= wr_data[0];
      if (reg_wr_c && (addr == ADDR_X)) new_flag <= 1'b0;

      if (start_c) begin
        timer      <= TMR_W'(POLL_PERIOD - 1);
        frame_init <= init_pending_c;
      end else if (!timer_done_c) begin
        timer <= timer - TMR_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_WAIT;
            timer <= '0;
          end
        end
        ST_WAIT: begin
          if (!enable) state <= ST_IDLE;
          else if (start_c) state <= ST_ASSERT;
        end
        ST_ASSERT:   if (assert_end_c) state <= ST_SHIFT;
        ST_SHIFT:    if (shift_end_c) state <= ST_DEASSERT;
        ST_DEASSERT: if (done_c) state <= ST_UPDATE;
        ST_UPDATE: begin
          // Set beats a same-cycle clear of new.
          if (!frame_init) begin
            x_q        <= rx_word[23:16];
            y_q        <= rx_word[15:8];
            z_q        <= rx_word[7:0];
            new_flag   <= 1'b1;
            sample_cnt <= sample_cnt + 16'd1;
          end
          if (!enable) state <= ST_IDLE;
          else if (start_c) state <= ST_ASSERT;
          else state <= ST_WAIT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATUS: rd_data = {29'd0, enable, busy_c, new_flag};
      ADDR_X:      rd_data = {{24{x_q[7]}}, x_q};
      ADDR_Y:      rd_data = {{24{y_q[7]}}, y_q};
      ADDR_Z:      rd_data = {{24{z_q[7]}}, z_q};
      ADDR_CNT:    rd_data = {16'd0, sample_cnt};
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_acl_poll_ctrl.sv
// Bench for acl_poll_ctrl: register tables, an ADXL362 sensor model and a frame scoreboard.
module tb_acl_poll_ctrl;

  localparam int unsigned DIV    = 2;
  localparam int unsigned PERIOD = 200;
  localparam int unsigned LIMIT  = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        acl_sclk;
  logic        acl_mosi;
  logic        acl_miso = 1'b0;
  logic        acl_ss_n;

  int checks = 0;
  int errors = 0;

  acl_poll_ctrl #(.SCLK_DIV(DIV), .POLL_PERIOD(PERIOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .write    (write),
    .read     (read),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .acl_sclk (acl_sclk),
    .acl_mosi (acl_mosi),
    .acl_miso (acl_miso),
    .acl_ss_n (acl_ss_n)
  );

  always #5 clk = ~clk;

  // Sensor model: shifts out {16'h0, X, Y, Z} and records what the master sent.
  bit          fixed_mode = 1'b1;
  logic [23:0] fixed_resp = 24'h05FE80;
  logic [23:0] cur_resp = '0;
  logic [39:0] resp_sr = '0;
  logic [39:0] mosi_sr = '0;
  logic [39:0] last_mosi = '0;
  int          low_cnt = 0, rises = 0, last_low = 0, last_rises = 0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0;
  logic [7:0]  sb_x = '0, sb_y = '0, sb_z = '0;
  int          sb_cnt = 0;

  always @(negedge clk) begin
    if (prev_ss && !acl_ss_n) begin
      cur_resp = fixed_mode ? fixed_resp : 24'($urandom);
      resp_sr  = {16'h0000, cur_resp};
      acl_miso = resp_sr[39];
      low_cnt  = 0;
      rises    = 0;
      mosi_sr  = '0;
    end
    if (!acl_ss_n) begin
      low_cnt++;
      if (!prev_sclk && acl_sclk) begin
        mosi_sr = {mosi_sr[38:0], acl_mosi};
        rises++;
      end
      if (prev_sclk && !acl_sclk) begin
        resp_sr  = {resp_sr[38:0], 1'b0};
        acl_miso = resp_sr[39];
      end
    end
    if (!prev_ss && acl_ss_n) begin
      last_low   = low_cnt;
      last_rises = rises;
      last_mosi  = mosi_sr;
      if (rises == 40) begin
        sb_x = cur_resp[23:16];
        sb_y = cur_resp[15:8];
        sb_z = cur_resp[7:0];
        sb_cnt++;
      end
    end
    prev_ss   = acl_ss_n;
    prev_sclk = acl_sclk;
  end

  function automatic logic [31:0] sx(input logic [7:0] b);
    return (b >= 8'd128) ? 32'(int'(b) - 256) : 32'(b);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; cs = 1'b1; read = 1'b1;
    #1 d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wr_now(input logic [4:0] a, input logic [31:0] d);
    addr = a; wr_data = d; cs = 1'b1; write = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic wait_ss(input logic lvl, input string nm);
    int n = 0;
    while (acl_ss_n !== lvl && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 64'(acl_ss_n), 64'(lvl));
  endtask

  // Returns shortly after the negedge inside the cycle following ss_n rise.
  task automatic wait_frame_end(input string nm);
    wait_ss(1'b0, nm);
    wait_ss(1'b1, nm);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic run_tbl(input string tag);
    logic [31:0] v;
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].d);
      end else begin
        rd(tbl[i].a, v);
        chk($sformatf("%s[%0d]_addr%0d", tag, i, tbl[i].a), 64'(v), 64'(tbl[i].exp));
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int n_low;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 64'(acl_ss_n), 64'd1);
    chk("rst_sclk", 64'(acl_sclk), 64'd0);
    chk("rst_mosi", 64'(acl_mosi), 64'd0);
    reset = 1'b0;
    tbl.delete();
    tbl.push_back('{1'b0, 5'd0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd1, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd2, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd3, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd4, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd5, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd31, 32'h0, 32'h0});
    run_tbl("reset_tbl");
    chk("idle_ss_n", 64'(acl_ss_n), 64'd1);

    // First poll with the fixed sensor sample
    wr(5'd0, 32'h1);
`ifdef ACL_POLL_INIT_EN
    wait_frame_end("init_frame");
    chk("init_mosi", 64'(last_mosi), 64'h0A2D02);
    chk("init_rises", 64'(last_rises), 64'd24);
    chk("init_low", 64'(last_low), 64'(50 * DIV));
`endif
    wait_frame_end("frame1");
    chk("frame1_mosi", 64'(last_mosi), 64'h0B08000000);
    chk("frame1_rises", 64'(last_rises), 64'd40);
    chk("frame1_low", 64'(last_low), 64'(82 * DIV));
    repeat (2) @(negedge clk);
    tbl.delete();
    tbl.push_back('{1'b0, 5'd0, 32'h0, 32'h5});
    tbl.push_back('{1'b0, 5'd1, 32'h0, 32'h5});
    tbl.push_back('{1'b0, 5'd2, 32'h0, 32'hFFFFFFFE});
    tbl.push_back('{1'b0, 5'd3, 32'h0, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 5'd4, 32'h0, 32'h1});
    tbl.push_back('{1'b0, 5'd9, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 5'd1, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 5'd0, 32'h0, 32'h4});
    run_tbl("frame1_tbl");

    // Clear during UPDATE loses to the set; clear during WAIT wins
    wait_frame_end("frame2");
    wr_now(5'd1, 32'h0);
    rd(5'd0, v);
    chk("clear_in_update_status", 64'(v), 64'h5);
    wr(5'd1, 32'h0);
    rd(5'd0, v);
    chk("clear_in_wait_status", 64'(v), 64'h4);

    // Random samples against the scoreboard
    fixed_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_frame_end($sformatf("rand%0d", i));
      repeat (2) @(negedge clk);
      rd(5'd1, v); chk($sformatf("rand%0d_x", i), 64'(v), 64'(sx(sb_x)));
      rd(5'd2, v); chk($sformatf("rand%0d_y", i), 64'(v), 64'(sx(sb_y)));
      rd(5'd3, v); chk($sformatf("rand%0d_z", i), 64'(v), 64'(sx(sb_z)));
      rd(5'd4, v); chk($sformatf("rand%0d_cnt", i), 64'(v), 64'(sb_cnt & 32'hFFFF));
    end

    // Disable mid-SHIFT: frame completes, then silence
    wait_ss(1'b0, "dis_start");
    repeat (20) @(negedge clk);
    wr(5'd0, 32'h0);
    wait_frame_end("dis_frame");
    chk("dis_rises", 64'(last_rises), 64'd40);
    repeat (2) @(negedge clk);
    rd(5'd4, v);
    chk("dis_cnt", 64'(v), 64'(sb_cnt & 32'hFFFF));
    rd(5'd1, v);
    chk("dis_x", 64'(v), 64'(sx(sb_x)));
    rd(5'd0, v);
    chk("dis_status", 64'(v), 64'h1);
    n_low = 0;
    repeat (600) begin
      @(negedge clk);
      if (acl_ss_n !== 1'b1) n_low++;
    end
    chk("dis_quiet_low_cycles", 64'(n_low), 64'd0);

    // Re-enable: plain read frame, no second init
    wr(5'd0, 32'h1);
    wait_frame_end("reen_frame");
    chk("reen_mosi", 64'(last_mosi), 64'h0B08000000);
    chk("reen_rises", 64'(last_rises), 64'd40);
    chk("reen_low", 64'(last_low), 64'(82 * DIV));

    // Reset mid-frame
    wait_ss(1'b0, "rstmid_start");
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_ss_n", 64'(acl_ss_n), 64'd1);
    chk("rstmid_sclk", 64'(acl_sclk), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd(5'(a), v);
      chk($sformatf("rstmid_addr%0d", a), 64'(v), 64'd0);
    end
    repeat (50) @(negedge clk);
    chk("rstmid_idle_ss_n", 64'(acl_ss_n), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
